// File: rtl/xmpl_dsp_pkg.sv
// Shared definitions for the filter-result reader.
// Holds the FSM state encoding, the default word width and FIFO depth,
// the index of the error bit inside the filter status word, and a
// saturating 16-bit increment used by the drop counter.
package xmpl_dsp_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 8;
  localparam int ERR_BIT   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc16 = v;
    end else begin
      sat_inc16 = v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/xmpl_flt_rdr_fifo.sv
// Result FIFO for the filter-result reader, first-word fall-through.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             synchronous flush (overrides push/pop)
//   push, wdata     write request and word; ignored when full unless a pop
//                   happens in the same cycle
//   pop             read request; only takes effect while vld is high
//   rdata, vld      registered head word and "FIFO not empty"
//   fill            registered occupancy, 0..DEPTH
// The head word is held in a register (reset to 0) rather than read
// straight out of the array, so rdata is defined after reset even though
// the storage itself is never reset.
module xmpl_flt_rdr_fifo
  import xmpl_dsp_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic                   vld,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] rd_ptr_nxt;
  logic [FW-1:0] fill_nxt;
  logic [DW-1:0] rdata_nxt;
  logic          pop_ok;
  logic          push_ok;

  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign pop_ok  = pop & vld & ~clr;
  assign push_ok = push & ~clr & ((fill != FW'(DEPTH)) | pop_ok);

  // Next pointers, occupancy and head word.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    fill_nxt   = fill;
    rdata_nxt  = rdata;
    if (clr) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      fill_nxt   = '0;
      rdata_nxt  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_nxt = wr_ptr + AW'(1'b1);
      end else begin
        wr_ptr_nxt = wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr_nxt = rd_ptr + AW'(1'b1);
      end else begin
        rd_ptr_nxt = rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   fill_nxt = fill + FW'(1'b1);
        2'b01:   fill_nxt = fill - FW'(1'b1);
        default: fill_nxt = fill;
      endcase
      // The next head is the incoming word when it lands in the slot the
      // read pointer is about to point at (empty FIFO, or last word popped
      // while a new one arrives); otherwise it is already in the array.
      if (fill_nxt == '0) begin
        rdata_nxt = rdata;
      end else if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
        rdata_nxt = wdata;
      end else begin
        rdata_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer, occupancy and head-word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      vld    <= 1'b0;
      rdata  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      fill   <= fill_nxt;
      vld    <= (fill_nxt != '0);
      rdata  <= rdata_nxt;
    end
  end

endmodule

// File: rtl/xmpl_flt_rdr.sv
// Filter-result reader: captures filter results into a FIFO while running
// and hands them out through a valid/ready read port.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   enable_i                capture enable (drives IDLE/RUN/DRAIN FSM)
//   clear_i                 synchronous flush of FIFO, counters, sticky flags
//   flt_vld_i, flt_data_i,
//   flt_status_i            one filter result per valid cycle; status bit
//                           ERR_BIT flags an error
//   rd_vld_o, rd_ready_i,
//   rd_data_o               read handshake, head word (fall-through)
//   fill_o                  FIFO occupancy
//   ovf_o, ovf_cnt_o        sticky overflow flag, saturating drop count
//   err_o                   sticky error seen on an accepted result
//   state_o                 FSM state (IDLE=0, RUN=1, DRAIN=2)
module xmpl_flt_rdr
  import xmpl_dsp_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic                   flt_vld_i,
  input  logic [DW-1:0]          flt_data_i,
  input  logic [DW-1:0]          flt_status_i,
  output logic                   rd_vld_o,
  input  logic                   rd_ready_i,
  output logic [DW-1:0]          rd_data_o,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   ovf_o,
  output logic [15:0]            ovf_cnt_o,
  output logic                   err_o,
  output logic [1:0]             state_o
);

  localparam int FW = $clog2(DEPTH) + 1;

  state_t state;
  state_t state_nxt;
  logic   in_run;
  logic   full;
  logic   pop;
  logic   push;
  logic   drop;
  logic   status_unused;

  // Only the error bit of the status word is of interest here.
  assign status_unused = ^flt_status_i;

  assign in_run = (state == ST_RUN);
  assign full   = (fill_o == FW'(DEPTH));
  assign pop    = rd_vld_o & rd_ready_i & ~clear_i;
  assign push   = in_run & flt_vld_i & (~full | pop) & ~clear_i;
  // Results arriving outside RUN are discarded silently; only a full FIFO
  // in RUN counts as an overflow.
  assign drop   = in_run & flt_vld_i & full & ~pop & ~clear_i;

  xmpl_flt_rdr_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (reset_i),
    .clr   (clear_i),
    .push  (push),
    .pop   (rd_ready_i),
    .wdata (flt_data_i),
    .rdata (rd_data_o),
    .vld   (rd_vld_o),
    .fill  (fill_o)
  );

  // Next-state logic for the capture FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable_i) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (enable_i) begin
          state_nxt = ST_RUN;
        end else if (fill_o != '0) begin
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // A flush empties the FIFO, so there is nothing left to drain.
        if (clear_i) begin
          state_nxt = ST_IDLE;
        end else if (enable_i) begin
          state_nxt = ST_RUN;
        end else if (fill_o == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign state_o = state;

  // Sticky overflow/error flags and saturating drop counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ovf_o     <= 1'b0;
      ovf_cnt_o <= 16'd0;
      err_o     <= 1'b0;
    end else if (clear_i) begin
      ovf_o     <= 1'b0;
      ovf_cnt_o <= 16'd0;
      err_o     <= 1'b0;
    end else begin
      if (drop) begin
        ovf_o     <= 1'b1;
        ovf_cnt_o <= sat_inc16(ovf_cnt_o);
      end
      if (push && flt_status_i[ERR_BIT]) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xmpl_flt_rdr.sv
module tb_xmpl_flt_rdr;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        flt_vld;
  logic [31:0] flt_data;
  logic [31:0] flt_status;
  logic        rd_vld;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [3:0]  fill;
  logic        ovf;
  logic [15:0] ovf_cnt;
  logic        err;
  logic [1:0]  state;

  int checks = 0;
  int passes = 0;

  // Scoreboard of words the bench expects to read back, plus flag model.
  logic [31:0] sb[$];
  int          m_state;
  bit          m_ovf;
  bit          m_err;
  int          m_cnt;

  xmpl_flt_rdr #(.DW(32), .DEPTH(8)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (enable),
    .clear_i     (clear),
    .flt_vld_i   (flt_vld),
    .flt_data_i  (flt_data),
    .flt_status_i(flt_status),
    .rd_vld_o    (rd_vld),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .fill_o      (fill),
    .ovf_o       (ovf),
    .ovf_cnt_o   (ovf_cnt),
    .err_o       (err),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    sb.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock: predict from the inputs, clock the DUT, update the model.
  task automatic step();
    int          f;
    int          nst;
    bit          run;
    bit          pop;
    bit          push;
    bit          drop;
    logic [31:0] d;
    logic        e;
    f    = sb.size();
    run  = (m_state == 1);
    pop  = (f > 0) && rd_ready && !clear;
    push = run && flt_vld && ((f < 8) || pop) && !clear;
    drop = run && flt_vld && (f == 8) && !pop && !clear;
    d    = flt_data;
    e    = flt_status[0];
    case (m_state)
      0:       nst = enable ? 1 : 0;
      1:       nst = enable ? 1 : ((f > 0) ? 2 : 0);
      2:       nst = clear ? 0 : (enable ? 1 : ((f == 0) ? 0 : 2));
      default: nst = 0;
    endcase
    @(posedge clk);
    #1;
    m_state = nst;
    if (clear) begin
      sb.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) begin
        sb.push_back(d);
        if (e) m_err = 1'b1;
      end
      if (drop) begin
        m_ovf = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; clear = 1'b0; flt_vld = 1'b0;
    flt_data = 32'd0; flt_status = 32'd0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({state, fill, rd_vld, ovf, err} !== 9'd0)
      $display("FAIL reset_ctrl: got state=%0d fill=%0d vld=%0b ovf=%0b err=%0b required all 0", state, fill, rd_vld, ovf, err);
    else passes++;
    checks++;
    if ({rd_data, ovf_cnt} !== 48'd0)
      $display("FAIL reset_data: got data=%0h cnt=%0d required 0/0", rd_data, ovf_cnt);
    else passes++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    logic [31:0] d [3];
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
    enable = 1'b1;
    step();
    checks++;
    if (state !== 2'd1) $display("FAIL idle_to_run: got %0d required 1", state);
    else passes++;
    rd_ready = 1'b1;
    flt_vld  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flt_data = d[i];
      step();
      checks++;
      if (rd_vld !== 1'b1 || rd_data !== d[i] || sb.size() != 1 || rd_data !== sb[0])
        $display("FAIL stream_word%0d: got vld=%0b data=%0h required vld=1 data=%0h", i, rd_vld, rd_data, d[i]);
      else passes++;
      checks++;
      if (fill !== 4'd1) $display("FAIL stream_fill%0d: got %0d required 1", i, fill);
      else passes++;
    end
    flt_vld = 1'b0;
    step();
    checks++;
    if (fill !== 4'd0 || rd_vld !== 1'b0)
      $display("FAIL stream_empty: got fill=%0d vld=%0b required 0/0", fill, rd_vld);
    else passes++;
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    rd_ready = 1'b0;
    flt_vld  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      flt_data   = 32'hA0 + 32'(i);
      flt_status = (i >= 8) ? 32'd1 : 32'd0;
      step();
    end
    checks++;
    if (fill !== 4'd8 || fill !== 4'(sb.size()))
      $display("FAIL ovf_fill: got %0d required 8", fill);
    else passes++;
    checks++;
    if (ovf !== 1'b1 || ovf_cnt !== 16'd2 || ovf_cnt !== 16'(m_cnt))
      $display("FAIL ovf_flag: got ovf=%0b cnt=%0d required 1/2", ovf, ovf_cnt);
    else passes++;
    checks++;
    if (err !== 1'b0) $display("FAIL ovf_err_dropped: got %0b required 0", err);
    else passes++;
    checks++;
    if (rd_data !== 32'hA0) $display("FAIL ovf_head: got %0h required a0", rd_data);
    else passes++;
    // Push and pop together while full.
    flt_data   = 32'hEE;
    flt_status = 32'd0;
    rd_ready   = 1'b1;
    step();
    checks++;
    if (fill !== 4'd8 || ovf_cnt !== 16'd2 || rd_data !== 32'hA1)
      $display("FAIL full_pushpop: got fill=%0d cnt=%0d data=%0h required 8/2/a1", fill, ovf_cnt, rd_data);
    else passes++;
    flt_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? (32'hA1 + 32'(i)) : 32'hEE;
      checks++;
      if (rd_vld !== 1'b1 || rd_data !== exp || rd_data !== sb[0])
        $display("FAIL ovf_read%0d: got vld=%0b data=%0h required 1/%0h", i, rd_vld, rd_data, exp);
      else passes++;
      step();
    end
    checks++;
    if (fill !== 4'd0 || rd_vld !== 1'b0)
      $display("FAIL ovf_drained: got fill=%0d vld=%0b required 0/0", fill, rd_vld);
    else passes++;
  endtask

  task automatic test_drain();
    int n;
    rd_ready = 1'b0;
    flt_vld  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flt_data = 32'hB0 + 32'(i);
      step();
    end
    enable  = 1'b0;
    flt_vld = 1'b0;
    step();
    checks++;
    if (state !== 2'd2 || fill !== 4'd3)
      $display("FAIL run_to_drain: got state=%0d fill=%0d required 2/3", state, fill);
    else passes++;
    flt_vld  = 1'b1;
    flt_data = 32'hFF;
    step();
    checks++;
    if (fill !== 4'd3 || ovf_cnt !== 16'd2 || ovf_cnt !== 16'(m_cnt))
      $display("FAIL drain_ignore: got fill=%0d cnt=%0d required 3/2", fill, ovf_cnt);
    else passes++;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data !== (32'hB0 + 32'(i)) || rd_data !== sb[0])
        $display("FAIL drain_read%0d: got %0h required %0h", i, rd_data, 32'hB0 + 32'(i));
      else passes++;
      step();
    end
    n = 0;
    while (state !== 2'd0 && n < 4) begin
      step();
      n++;
    end
    checks++;
    if (state !== 2'd0 || fill !== 4'd0)
      $display("FAIL drain_to_idle: got state=%0d fill=%0d required 0/0", state, fill);
    else passes++;
    flt_vld = 1'b0;
  endtask

  task automatic test_clear();
    enable   = 1'b1;
    rd_ready = 1'b0;
    step();
    flt_vld    = 1'b1;
    flt_data   = 32'hC0;
    flt_status = 32'd1;
    step();
    checks++;
    if (err !== 1'b1 || err !== m_err || fill !== 4'd1)
      $display("FAIL err_set: got err=%0b fill=%0d required 1/1", err, fill);
    else passes++;
    flt_status = 32'd0;
    flt_data   = 32'hC1;
    step();
    flt_vld = 1'b0;
    clear   = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({err, ovf, ovf_cnt, fill, rd_vld} !== 23'd0)
      $display("FAIL clear_flush: got err=%0b ovf=%0b cnt=%0d fill=%0d vld=%0b required all 0", err, ovf, ovf_cnt, fill, rd_vld);
    else passes++;
    checks++;
    if (state !== 2'd1) $display("FAIL clear_run_state: got %0d required 1", state);
    else passes++;
    flt_vld  = 1'b1;
    flt_data = 32'hC2;
    step();
    flt_vld = 1'b0;
    enable  = 1'b0;
    step();
    checks++;
    if (state !== 2'd2) $display("FAIL clear_pre_drain: got %0d required 2", state);
    else passes++;
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (state !== 2'd0 || fill !== 4'd0 || state !== 2'(m_state))
      $display("FAIL clear_drain_idle: got state=%0d fill=%0d required 0/0", state, fill);
    else passes++;
  endtask

  task automatic test_reset_mid();
    enable   = 1'b1;
    rd_ready = 1'b0;
    step();
    flt_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flt_data   = 32'hE0 + 32'(i);
      flt_status = (i == 1) ? 32'd1 : 32'd0;
      step();
    end
    checks++;
    if (fill !== 4'd3 || err !== 1'b1)
      $display("FAIL pre_reset: got fill=%0d err=%0b required 3/1", fill, err);
    else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({state, fill, rd_vld, ovf, err, ovf_cnt} !== 25'd0 || rd_data !== 32'd0)
      $display("FAIL async_reset: got state=%0d fill=%0d vld=%0b err=%0b data=%0h required all 0", state, fill, rd_vld, err, rd_data);
    else passes++;
    flt_vld    = 1'b0;
    flt_status = 32'd0;
    enable     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    enable = 1'b1;
    step();
    flt_vld  = 1'b1;
    flt_data = 32'hD0;
    step();
    flt_vld = 1'b0;
    checks++;
    if (fill !== 4'd1 || rd_vld !== 1'b1 || rd_data !== 32'hD0 || rd_data !== sb[0])
      $display("FAIL post_reset_push: got fill=%0d vld=%0b data=%0h required 1/1/d0", fill, rd_vld, rd_data);
    else passes++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_overflow();
    test_drain();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
